// File: rtl/act_pkg.sv
// Fixed-point format shared by the tanh and sigmoid activation LUTs.
package act_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int FRACT_WIDTH = 5;
  localparam int ONE_Q       = 1 << FRACT_WIDTH;

  typedef logic signed [DATA_WIDTH-1:0] q_t;

endpackage

// File: rtl/tanh_rom.sv
// Combinational tanh table, Q3.5 in and out, contents generated offline and checked in.
module tanh_rom
  import act_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] word
);

  if (DW != DATA_WIDTH || AW > DATA_WIDTH) begin : g_bad_params
    $error("tanh_rom: DW must equal DATA_WIDTH and AW must not exceed DATA_WIDTH");
  end

  // A short address k names the full operand {k, zeros}, so one full-width table serves every AW.
  logic [DATA_WIDTH-1:0] full;
  q_t                    entry;

  always_comb begin
    full                  = '0;
    full[DATA_WIDTH-1 -: AW] = addr;
  end

  always_comb begin
    entry = '0;
    case (full)
      8'h00: entry = 8'h00; 8'h01: entry = 8'h01; 8'h02: entry = 8'h02; 8'h03: entry = 8'h03; 8'h04: entry = 8'h04; 8'h05: entry = 8'h05; 8'h06: entry = 8'h06; 8'h07: entry = 8'h07;
      8'h08: entry = 8'h08; 8'h09: entry = 8'h09; 8'h0A: entry = 8'h0A; 8'h0B: entry = 8'h0B; 8'h0C: entry = 8'h0B; 8'h0D: entry = 8'h0C; 8'h0E: entry = 8'h0D; 8'h0F: entry = 8'h0E;
      8'h10: entry = 8'h0F; 8'h11: entry = 8'h10; 8'h12: entry = 8'h10; 8'h13: entry = 8'h11; 8'h14: entry = 8'h12; 8'h15: entry = 8'h12; 8'h16: entry = 8'h13; 8'h17: entry = 8'h14;
      8'h18: entry = 8'h14; 8'h19: entry = 8'h15; 8'h1A: entry = 8'h15; 8'h1B: entry = 8'h16; 8'h1C: entry = 8'h17; 8'h1D: entry = 8'h17; 8'h1E: entry = 8'h17; 8'h1F: entry = 8'h18;
      8'h20: entry = 8'h18; 8'h21: entry = 8'h19; 8'h22: entry = 8'h19; 8'h23: entry = 8'h1A; 8'h24: entry = 8'h1A; 8'h25: entry = 8'h1A; 8'h26: entry = 8'h1B; 8'h27: entry = 8'h1B;
      8'h28: entry = 8'h1B; 8'h29: entry = 8'h1B; 8'h2A: entry = 8'h1C; 8'h2B: entry = 8'h1C; 8'h2C: entry = 8'h1C; 8'h2D: entry = 8'h1C; 8'h2E: entry = 8'h1D; 8'h2F: entry = 8'h1D;
      8'h30: entry = 8'h1D; 8'h31: entry = 8'h1D; 8'h32: entry = 8'h1D; 8'h33: entry = 8'h1D; 8'h34: entry = 8'h1E; 8'h35: entry = 8'h1E; 8'h36: entry = 8'h1E; 8'h37: entry = 8'h1E;
      8'h38: entry = 8'h1E; 8'h39: entry = 8'h1E; 8'h3A: entry = 8'h1E; 8'h3B: entry = 8'h1E; 8'h3C: entry = 8'h1F; 8'h3D: entry = 8'h1F; 8'h3E: entry = 8'h1F; 8'h3F: entry = 8'h1F;
      8'h40: entry = 8'h1F; 8'h41: entry = 8'h1F; 8'h42: entry = 8'h1F; 8'h43: entry = 8'h1F; 8'h44: entry = 8'h1F; 8'h45: entry = 8'h1F; 8'h46: entry = 8'h1F; 8'h47: entry = 8'h1F;
      8'h48: entry = 8'h1F; 8'h49: entry = 8'h1F; 8'h4A: entry = 8'h1F; 8'h4B: entry = 8'h1F; 8'h4C: entry = 8'h1F; 8'h4D: entry = 8'h1F; 8'h4E: entry = 8'h20; 8'h4F: entry = 8'h20;
      8'h50: entry = 8'h20; 8'h51: entry = 8'h20; 8'h52: entry = 8'h20; 8'h53: entry = 8'h20; 8'h54: entry = 8'h20; 8'h55: entry = 8'h20; 8'h56: entry = 8'h20; 8'h57: entry = 8'h20;
      8'h58: entry = 8'h20; 8'h59: entry = 8'h20; 8'h5A: entry = 8'h20; 8'h5B: entry = 8'h20; 8'h5C: entry = 8'h20; 8'h5D: entry = 8'h20; 8'h5E: entry = 8'h20; 8'h5F: entry = 8'h20;
      8'h60: entry = 8'h20; 8'h61: entry = 8'h20; 8'h62: entry = 8'h20; 8'h63: entry = 8'h20; 8'h64: entry = 8'h20; 8'h65: entry = 8'h20; 8'h66: entry = 8'h20; 8'h67: entry = 8'h20;
      8'h68: entry = 8'h20; 8'h69: entry = 8'h20; 8'h6A: entry = 8'h20; 8'h6B: entry = 8'h20; 8'h6C: entry = 8'h20; 8'h6D: entry = 8'h20; 8'h6E: entry = 8'h20; 8'h6F: entry = 8'h20;
      8'h70: entry = 8'h20; 8'h71: entry = 8'h20; 8'h72: entry = 8'h20; 8'h73: entry = 8'h20; 8'h74: entry = 8'h20; 8'h75: entry = 8'h20; 8'h76: entry = 8'h20; 8'h77: entry = 8'h20;
      8'h78: entry = 8'h20; 8'h79: entry = 8'h20; 8'h7A: entry = 8'h20; 8'h7B: entry = 8'h20; 8'h7C: entry = 8'h20; 8'h7D: entry = 8'h20; 8'h7E: entry = 8'h20; 8'h7F: entry = 8'h20;
      8'h80: entry = 8'hE0; 8'h81: entry = 8'hE0; 8'h82: entry = 8'hE0; 8'h83: entry = 8'hE0; 8'h84: entry = 8'hE0; 8'h85: entry = 8'hE0; 8'h86: entry = 8'hE0; 8'h87: entry = 8'hE0;
      8'h88: entry = 8'hE0; 8'h89: entry = 8'hE0; 8'h8A: entry = 8'hE0; 8'h8B: entry = 8'hE0; 8'h8C: entry = 8'hE0; 8'h8D: entry = 8'hE0; 8'h8E: entry = 8'hE0; 8'h8F: entry = 8'hE0;
      8'h90: entry = 8'hE0; 8'h91: entry = 8'hE0; 8'h92: entry = 8'hE0; 8'h93: entry = 8'hE0; 8'h94: entry = 8'hE0; 8'h95: entry = 8'hE0; 8'h96: entry = 8'hE0; 8'h97: entry = 8'hE0;
      8'h98: entry = 8'hE0; 8'h99: entry = 8'hE0; 8'h9A: entry = 8'hE0; 8'h9B: entry = 8'hE0; 8'h9C: entry = 8'hE0; 8'h9D: entry = 8'hE0; 8'h9E: entry = 8'hE0; 8'h9F: entry = 8'hE0;
      8'hA0: entry = 8'hE0; 8'hA1: entry = 8'hE0; 8'hA2: entry = 8'hE0; 8'hA3: entry = 8'hE0; 8'hA4: entry = 8'hE0; 8'hA5: entry = 8'hE0; 8'hA6: entry = 8'hE0; 8'hA7: entry = 8'hE0;
      8'hA8: entry = 8'hE0; 8'hA9: entry = 8'hE0; 8'hAA: entry = 8'hE0; 8'hAB: entry = 8'hE0; 8'hAC: entry = 8'hE0; 8'hAD: entry = 8'hE0; 8'hAE: entry = 8'hE0; 8'hAF: entry = 8'hE0;
      8'hB0: entry = 8'hE0; 8'hB1: entry = 8'hE0; 8'hB2: entry = 8'hE0; 8'hB3: entry = 8'hE1; 8'hB4: entry = 8'hE1; 8'hB5: entry = 8'hE1; 8'hB6: entry = 8'hE1; 8'hB7: entry = 8'hE1;
      8'hB8: entry = 8'hE1; 8'hB9: entry = 8'hE1; 8'hBA: entry = 8'hE1; 8'hBB: entry = 8'hE1; 8'hBC: entry = 8'hE1; 8'hBD: entry = 8'hE1; 8'hBE: entry = 8'hE1; 8'hBF: entry = 8'hE1;
      8'hC0: entry = 8'hE1; 8'hC1: entry = 8'hE1; 8'hC2: entry = 8'hE1; 8'hC3: entry = 8'hE1; 8'hC4: entry = 8'hE1; 8'hC5: entry = 8'hE2; 8'hC6: entry = 8'hE2; 8'hC7: entry = 8'hE2;
      8'hC8: entry = 8'hE2; 8'hC9: entry = 8'hE2; 8'hCA: entry = 8'hE2; 8'hCB: entry = 8'hE2; 8'hCC: entry = 8'hE2; 8'hCD: entry = 8'hE3; 8'hCE: entry = 8'hE3; 8'hCF: entry = 8'hE3;
      8'hD0: entry = 8'hE3; 8'hD1: entry = 8'hE3; 8'hD2: entry = 8'hE3; 8'hD3: entry = 8'hE4; 8'hD4: entry = 8'hE4; 8'hD5: entry = 8'hE4; 8'hD6: entry = 8'hE4; 8'hD7: entry = 8'hE5;
      8'hD8: entry = 8'hE5; 8'hD9: entry = 8'hE5; 8'hDA: entry = 8'hE5; 8'hDB: entry = 8'hE6; 8'hDC: entry = 8'hE6; 8'hDD: entry = 8'hE6; 8'hDE: entry = 8'hE7; 8'hDF: entry = 8'hE7;
      8'hE0: entry = 8'hE8; 8'hE1: entry = 8'hE8; 8'hE2: entry = 8'hE9; 8'hE3: entry = 8'hE9; 8'hE4: entry = 8'hE9; 8'hE5: entry = 8'hEA; 8'hE6: entry = 8'hEB; 8'hE7: entry = 8'hEB;
      8'hE8: entry = 8'hEC; 8'hE9: entry = 8'hEC; 8'hEA: entry = 8'hED; 8'hEB: entry = 8'hEE; 8'hEC: entry = 8'hEE; 8'hED: entry = 8'hEF; 8'hEE: entry = 8'hF0; 8'hEF: entry = 8'hF0;
      8'hF0: entry = 8'hF1; 8'hF1: entry = 8'hF2; 8'hF2: entry = 8'hF3; 8'hF3: entry = 8'hF4; 8'hF4: entry = 8'hF5; 8'hF5: entry = 8'hF5; 8'hF6: entry = 8'hF6; 8'hF7: entry = 8'hF7;
      8'hF8: entry = 8'hF8; 8'hF9: entry = 8'hF9; 8'hFA: entry = 8'hFA; 8'hFB: entry = 8'hFB; 8'hFC: entry = 8'hFC; 8'hFD: entry = 8'hFD; 8'hFE: entry = 8'hFE; 8'hFF: entry = 8'hFF;
      default: entry = '0;
    endcase
  end

  assign word = entry;

endmodule

// File: rtl/tanh_lut_sync.sv
// Registered tanh activation: top-AW-bit address into the tanh table, one clock of latency.
module tanh_lut_sync #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int DATA_WIDTH  = act_pkg::DATA_WIDTH,
  parameter int FRACT_WIDTH = act_pkg::FRACT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  output logic [DW-1:0]         y
);

  if (DW != DATA_WIDTH || AW > DATA_WIDTH) begin : g_bad_params
    $error("tanh_lut_sync: DW must equal DATA_WIDTH and AW must not exceed DATA_WIDTH");
  end

  // The checked-in table was generated for one Q format only.
  if (DATA_WIDTH != act_pkg::DATA_WIDTH || FRACT_WIDTH != act_pkg::FRACT_WIDTH) begin : g_bad_format
    $error("tanh_lut_sync: table contents only exist for the act_pkg Q format");
  end

  logic [AW-1:0] addr;
  logic [DW-1:0] word;

  assign addr = a[DATA_WIDTH-1 -: AW];

  tanh_rom #(
    .AW(AW),
    .DW(DW)
  ) u_rom (
    .addr(addr),
    .word(word)
  );

  always_ff @(posedge clk) begin
    if (rst) y <= '0;
    else     y <= word;
  end

endmodule

// File: tb/tb_tanh_lut_sync.sv
// Directed checks of tanh_lut_sync against hand values and a real-arithmetic tanh model.
module tb_tanh_lut_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] y;

  int passes = 0;
  int checks = 0;
  int fails  = 0;

  logic [7:0] res [256];

  tanh_lut_sync #(
    .AW(8),
    .DW(8),
    .DATA_WIDTH(8),
    .FRACT_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .y(y)
  );

  always #5 clk = ~clk;

  // round(tanh(x) * 32), ties away from zero, saturated to 8-bit signed.
  function automatic logic [7:0] golden(input logic [7:0] addr);
    int  s;
    int  r;
    real v;
    s = int'($signed(addr));
    v = $tanh($itor(s) / 32.0) * 32.0;
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(-v + 0.5);
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return 8'(r);
  endfunction

  // Drive on the falling edge so exactly one rising edge separates drive and check.
  task automatic apply_stimulus(input logic [7:0] val, input logic rst_val);
    a   = val;
    rst = rst_val;
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [7:0] expected);
    checks++;
    assert (y === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: y=0x%02h expected 0x%02h", tag, y, expected);
    end
  endtask

  initial begin
    logic [7:0] neg;
    logic [7:0] exp_y;
    logic [7:0] val;
    logic       r;

    rst = 1'b1;
    a   = 8'h20;
    @(negedge clk);
    check_output("reset_edge1", 8'h00);
    apply_stimulus(8'h20, 1'b1);
    check_output("reset_edge2", 8'h00);
    apply_stimulus(8'h20, 1'b1);
    check_output("reset_edge3", 8'h00);
    apply_stimulus(8'h20, 1'b0);
    check_output("release_1p0", 8'h18);

    apply_stimulus(8'h00, 1'b0); check_output("x_0p0",    8'h00);
    apply_stimulus(8'h08, 1'b0); check_output("x_0p25",   8'h08);
    apply_stimulus(8'h10, 1'b0); check_output("x_0p5",    8'h0F);
    apply_stimulus(8'h20, 1'b0); check_output("x_1p0",    8'h18);
    apply_stimulus(8'h40, 1'b0); check_output("x_2p0",    8'h1F);
    apply_stimulus(8'hE0, 1'b0); check_output("x_m1p0",   8'hE8);
    apply_stimulus(8'hF0, 1'b0); check_output("x_m0p5",   8'hF1);
    apply_stimulus(8'h7F, 1'b0); check_output("x_max",    8'h20);
    apply_stimulus(8'h80, 1'b0); check_output("x_min",    8'hE0);
    apply_stimulus(8'h0C, 1'b0); check_output("x_0p375",  8'h0B);
    apply_stimulus(8'h1A, 1'b0); check_output("x_0p8125", 8'h15);
    apply_stimulus(8'h1E, 1'b0); check_output("x_0p9375", 8'h17);
    apply_stimulus(8'h4E, 1'b0); check_output("x_sat_in", 8'h20);
    apply_stimulus(8'h4D, 1'b0); check_output("x_sat_pre", 8'h1F);

    // Back-to-back sweep: a new operand every cycle, each result one edge later.
    for (int i = 0; i < 256; i++) begin
      apply_stimulus(8'(i), 1'b0);
      check_output($sformatf("sweep[%0d]", i), golden(8'(i)));
      res[i] = y;
    end

    for (int k = 1; k < 128; k++) begin
      neg = 8'(-int'($signed(res[k])));
      checks++;
      assert (res[256 - k] === neg) passes++;
      else begin
        fails++;
        $error("[TB] FAIL odd_sym[%0d]: y=0x%02h expected 0x%02h", k, res[256 - k], neg);
      end
    end

    for (int i = -128; i < 127; i++) begin
      checks++;
      assert ($signed(res[8'(i + 1)]) >= $signed(res[8'(i)])) passes++;
      else begin
        fails++;
        $error("[TB] FAIL monotonic[%0d]: y=0x%02h expected at least 0x%02h", i + 1, res[8'(i + 1)], res[8'(i)]);
      end
    end

    // Reset pulse mid-stream must drop the in-flight result and then resume cleanly.
    for (int i = 0; i < 64; i++) begin
      val   = 8'(i * 37 + 5);
      r     = (i == 30);
      exp_y = r ? 8'h00 : golden(val);
      apply_stimulus(val, r);
      check_output($sformatf("midrst[%0d]", i), exp_y);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
